// File: rtl/retire_trace_buffer.sv
// Circular trace buffer of retired instructions: armed by start, stops when full (mode 1) or
// POST writes after a trigger, then drains oldest-first through a valid/ready read port.
module retire_trace_buffer #(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int POST  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   trig,
    input  logic [LANES-1:0]       lane_valid,
    input  logic [32*LANES-1:0]    lane_ins,
    input  logic [32*LANES-1:0]    lane_result,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [15:0]            rd_stamp,
    output logic [LANES-1:0]       rd_mask,
    output logic [32*LANES-1:0]    rd_ins,
    output logic [32*LANES-1:0]    rd_result,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (POST > 0) ? $clog2(POST + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
    localparam logic [PW-1:0] POST_LD  = PW'(POST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q;
    logic            mode_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic            overflow_q;
    logic [PW-1:0]   post_cnt_q;
    logic [15:0]     stamp_q;

    logic [15:0]          stamp_mem  [DEPTH];
    logic [LANES-1:0]     mask_mem   [DEPTH];
    logic [32*LANES-1:0]  ins_mem    [DEPTH];
    logic [32*LANES-1:0]  result_mem [DEPTH];

    logic wr_en;
    logic full;
    logic pop;

    assign wr_en    = ((state_q == S_CAPTURE) || (state_q == S_POST)) && (|lane_valid);
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = (state_q == S_DONE) && (count_q != '0);
    assign pop      = rd_valid && rd_ready;

    assign rd_stamp  = stamp_mem[rd_ptr_q];
    assign rd_mask   = mask_mem[rd_ptr_q];
    assign rd_ins    = ins_mem[rd_ptr_q];
    assign rd_result = result_mem[rd_ptr_q];
    assign count     = count_q;
    assign state     = state_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            stamp_mem[wr_ptr_q]  <= stamp_q;
            mask_mem[wr_ptr_q]   <= lane_valid;
            ins_mem[wr_ptr_q]    <= lane_ins;
            result_mem[wr_ptr_q] <= lane_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            post_cnt_q <= '0;
            stamp_q    <= '0;
        end else begin
            stamp_q <= stamp_q + 16'd1;
            // A write into a full buffer (wrap mode only) drops the oldest entry.
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (full) begin
                    rd_ptr_q   <= rd_ptr_q + AW'(1);
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_CAPTURE;
                        mode_q     <= mode;
                        count_q    <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (wr_en && mode_q && (count_q == LAST_CNT)) begin
                        state_q <= S_DONE;
                    end else if (trig) begin
                        state_q    <= (POST == 0) ? S_DONE : S_POST;
                        post_cnt_q <= POST_LD;
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_cnt_q <= post_cnt_q - PW'(1);
                        if ((post_cnt_q == PW'(1)) || (mode_q && (count_q == LAST_CNT))) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (count_q == '0) begin
                        state_q <= S_IDLE;
                    end else if (pop) begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        count_q  <= count_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer with default parameters (LANES=2, DEPTH=16, POST=4).
module tb_retire_trace_buffer;
    logic        clk = 1'b0;
    logic        rst, start, mode, trig, rd_ready;
    logic [1:0]  lane_valid;
    logic [63:0] lane_ins, lane_result;
    logic        rd_valid;
    logic [15:0] rd_stamp;
    logic [1:0]  rd_mask;
    logic [63:0] rd_ins, rd_result;
    logic [4:0]  count;
    logic [1:0]  state;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    retire_trace_buffer #(.LANES(2), .DEPTH(16), .POST(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .trig(trig),
        .lane_valid(lane_valid), .lane_ins(lane_ins), .lane_result(lane_result),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_stamp(rd_stamp),
        .rd_mask(rd_mask), .rd_ins(rd_ins), .rd_result(rd_result),
        .count(count), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] s0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; trig = 1'b0; rd_ready = 1'b0;
        lane_valid = 2'b00; lane_ins = '0; lane_result = '0;
        step(); step();
        rst = 1'b0;
        check("reset_state", 64'(state), 64'd0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_rdv", 64'(rd_valid), 64'd0);

        // Stop-when-full capture of 16 dual-lane writes, then full drain.
        start = 1'b1; mode = 1'b1;
        step();
        start = 1'b0;
        check("t1_capture", 64'(state), 64'd1);
        for (int i = 0; i < 16; i++) begin
            lane_valid = 2'b11;
            lane_ins = {32'(1000 + i), 32'(i)};
            lane_result = {32'(3000 + i), 32'(2000 + i)};
            step();
        end
        lane_valid = 2'b00;
        check("t1_done", 64'(state), 64'd3);
        check("t1_count", 64'(count), 64'd16);
        check("t1_rdv", 64'(rd_valid), 64'd1);
        check("t1_lane1_ins", rd_ins, {32'd1000, 32'd0});
        check("t1_result", rd_result, {32'd3000, 32'd2000});
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("t1_ins%0d", j), 64'(rd_ins[31:0]), 64'(j));
            check($sformatf("t1_stamp%0d", j), 64'(rd_stamp), 64'(1 + j));
            step();
        end
        check("t1_drained_rdv", 64'(rd_valid), 64'd0);
        check("t1_drained_cnt", 64'(count), 64'd0);
        step();
        rd_ready = 1'b0;
        check("t1_idle", 64'(state), 64'd0);

        // Wrap mode: trigger on write 15, four post writes overwrite the four oldest.
        start = 1'b1; mode = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            lane_valid = 2'b11;
            lane_ins = {32'(500 + i), 32'(100 + i)};
            trig = (i == 15);
            step();
            check($sformatf("t2_state%0d", i), 64'(state),
                  (i < 15) ? 64'd1 : ((i < 19) ? 64'd2 : 64'd3));
            if (i == 15) check("t2_ovf_at_full", 64'(overflow), 64'd0);
        end
        lane_valid = 2'b00; trig = 1'b0;
        check("t2_count", 64'(count), 64'd16);
        check("t2_ovf", 64'(overflow), 64'd1);
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("t2_ins%0d", j), 64'(rd_ins[31:0]), 64'(104 + j));
            step();
        end
        step();
        rd_ready = 1'b0;
        check("t2_idle", 64'(state), 64'd0);

        // Alternating 00/01 lane valid; only 01 cycles are stored.
        start = 1'b1; mode = 1'b1;
        step();
        start = 1'b0;
        check("t3_ovf_cleared", 64'(overflow), 64'd0);
        check("t3_count_cleared", 64'(count), 64'd0);
        for (int i = 0; i < 16; i++) begin
            lane_valid = i[0] ? 2'b01 : 2'b00;
            lane_ins = {32'hdead_beef, 32'(200 + i)};
            trig = (i == 7);
            step();
            if (i == 14) check("t3_still_post", 64'(state), 64'd2);
        end
        lane_valid = 2'b00; trig = 1'b0;
        check("t3_done", 64'(state), 64'd3);
        check("t3_count", 64'(count), 64'd8);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t3_hold_ins%0d", k), 64'(rd_ins[31:0]), 64'd201);
            check($sformatf("t3_hold_cnt%0d", k), 64'(count), 64'd8);
        end
        s0 = rd_stamp;
        rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t3_mask%0d", j), 64'(rd_mask), 64'd1);
            check($sformatf("t3_ins%0d", j), 64'(rd_ins[31:0]), 64'(201 + 2 * j));
            if (j > 0) check($sformatf("t3_stamp%0d", j), 64'(rd_stamp), 64'(16'(s0 + 16'(2 * j))));
            step();
        end
        step();
        rd_ready = 1'b0;
        check("t3_idle", 64'(state), 64'd0);

        // Start ignored mid-capture, rd_ready ignored without valid, reset in POST.
        start = 1'b1; mode = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            start = (i == 1);
            mode = (i == 1);
            lane_valid = 2'b11;
            lane_ins = {32'd0, 32'(300 + i)};
            trig = (i == 4);
            rd_ready = 1'b1;
            step();
        end
        start = 1'b0; trig = 1'b0; lane_valid = 2'b00;
        check("t4_post", 64'(state), 64'd2);
        check("t4_count", 64'(count), 64'd7);
        check("t4_rdv", 64'(rd_valid), 64'd0);
        rst = 1'b1; trig = 1'b1; start = 1'b1; lane_valid = 2'b11;
        step();
        check("t4_rst_state", 64'(state), 64'd0);
        check("t4_rst_count", 64'(count), 64'd0);
        check("t4_rst_rdv", 64'(rd_valid), 64'd0);
        check("t4_rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0; trig = 1'b0; start = 1'b0; lane_valid = 2'b00; rd_ready = 1'b0;
        step();
        check("t4_stay_idle", 64'(state), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
